// File: rtl/np_comp_bank_pkg.sv
// Shared defaults and the redundant-row entry record for the repair compare bank.
package np_comp_bank_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int BLK_W_DEF  = 2;
  localparam int N_ENT_DEF  = 4;

  // A local spare only matches inside its own block; a global spare matches any block.
  typedef struct packed {
    logic                  valid;
    logic                  is_local;
    logic [BLK_W_DEF-1:0]  blk;
    logic [ADDR_W_DEF-1:0] addr;
  } entry_t;

endpackage

// File: rtl/ra_cmp_cell.sv
// Single redundant-row entry compare: address match, block-qualified only for local spares.
module ra_cmp_cell
  import np_comp_bank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BLK_W  = BLK_W_DEF
) (
  input  logic              ent_valid_i,
  input  logic              ent_local_i,
  input  logic [BLK_W-1:0]  ent_blk_i,
  input  logic [ADDR_W-1:0] ent_addr_i,
  input  logic [BLK_W-1:0]  cmp_blk_i,
  input  logic [ADDR_W-1:0] cmp_addr_i,
  output logic              match_o
);

  assign match_o = ent_valid_i
                && (ent_addr_i == cmp_addr_i)
                && (!ent_local_i || (ent_blk_i == cmp_blk_i));

endmodule

// File: rtl/np_comp_bank.sv
// Redundant-row CAM bank: append-only allocation plus a one-cycle registered compare
// with lowest-index priority and multi-hit detection.
module np_comp_bank
  import np_comp_bank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BLK_W  = BLK_W_DEF,
  parameter int N_ENT  = N_ENT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       alloc_valid,
  input  logic [ADDR_W-1:0]          alloc_addr,
  input  logic [BLK_W-1:0]           alloc_blk,
  input  logic                       alloc_local,
  output logic                       alloc_done,
  output logic                       alloc_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [BLK_W-1:0]           in_blk,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_hit,
  output logic [$clog2(N_ENT)-1:0]   out_idx,
  output logic                       out_multi,
  output logic [$clog2(N_ENT+1)-1:0] count,
  output logic                       full
);

  localparam int IDX_W = $clog2(N_ENT);
  localparam int CNT_W = $clog2(N_ENT+1);

  // Same layout as the package record, but sized by this instance's parameters.
  typedef struct packed {
    logic              valid;
    logic              is_local;
    logic [BLK_W-1:0]  blk;
    logic [ADDR_W-1:0] addr;
  } rec_t;

  rec_t [N_ENT-1:0] ent_q, ent_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             out_hit_q, out_hit_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_multi_q, out_multi_d;
  logic             alloc_done_q, alloc_done_d;
  logic             alloc_err_q, alloc_err_d;

  logic [N_ENT-1:0] match;
  logic [IDX_W-1:0] hit_idx;
  logic             accept;
  logic             alloc_ok;
  logic             full_w;

  for (genvar g = 0; g < N_ENT; g++) begin : g_cell
    ra_cmp_cell #(
      .ADDR_W (ADDR_W),
      .BLK_W  (BLK_W)
    ) u_cell (
      .ent_valid_i (ent_q[g].valid),
      .ent_local_i (ent_q[g].is_local),
      .ent_blk_i   (ent_q[g].blk),
      .ent_addr_i  (ent_q[g].addr),
      .cmp_blk_i   (in_blk),
      .cmp_addr_i  (in_addr),
      .match_o     (match[g])
    );
  end

  assign full_w   = (count_q == CNT_W'(N_ENT));
  assign in_ready = !clr && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign alloc_ok = alloc_valid && !full_w && !clr;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_idx = '0;
    for (int i = N_ENT-1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDX_W'(i);
    end
  end

  always_comb begin
    ent_d        = ent_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_hit_d    = out_hit_q;
    out_idx_d    = out_idx_q;
    out_multi_d  = out_multi_q;
    alloc_done_d = 1'b0;
    alloc_err_d  = 1'b0;
    if (clr) begin
      for (int i = 0; i < N_ENT; i++) ent_d[i].valid = 1'b0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_hit_d   = 1'b0;
      out_idx_d   = '0;
      out_multi_d = 1'b0;
    end else begin
      alloc_done_d = alloc_valid;
      alloc_err_d  = alloc_valid && full_w;
      if (alloc_ok) begin
        for (int i = 0; i < N_ENT; i++) begin
          if (count_q == CNT_W'(i)) begin
            ent_d[i].valid    = 1'b1;
            ent_d[i].is_local = alloc_local;
            ent_d[i].blk      = alloc_blk;
            ent_d[i].addr     = alloc_addr;
          end
        end
        count_d = count_q + CNT_W'(1);
      end
      // A word with two or more set bits survives clearing its lowest set bit.
      if (accept) begin
        out_valid_d = 1'b1;
        out_hit_d   = |match;
        out_idx_d   = hit_idx;
        out_multi_d = |(match & (match - N_ENT'(1)));
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q        <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_hit_q    <= 1'b0;
      out_idx_q    <= '0;
      out_multi_q  <= 1'b0;
      alloc_done_q <= 1'b0;
      alloc_err_q  <= 1'b0;
    end else begin
      ent_q        <= ent_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_hit_q    <= out_hit_d;
      out_idx_q    <= out_idx_d;
      out_multi_q  <= out_multi_d;
      alloc_done_q <= alloc_done_d;
      alloc_err_q  <= alloc_err_d;
    end
  end

  assign count      = count_q;
  assign full       = full_w;
  assign out_valid  = out_valid_q;
  assign out_hit    = out_hit_q;
  assign out_idx    = out_idx_q;
  assign out_multi  = out_multi_q;
  assign alloc_done = alloc_done_q;
  assign alloc_err  = alloc_err_q;

endmodule

// File: tb/tb_np_comp_bank.sv
// Directed scoreboard bench for np_comp_bank: stimulus pushes expected results,
// a negedge monitor pops them whenever the DUT presents a result or alloc pulse.
module tb_np_comp_bank;
  import np_comp_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       alloc_valid;
  logic [9:0] alloc_addr;
  logic [1:0] alloc_blk;
  logic       alloc_local;
  logic       alloc_done;
  logic       alloc_err;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_addr;
  logic [1:0] in_blk;
  logic       out_valid;
  logic       out_ready;
  logic       out_hit;
  logic [1:0] out_idx;
  logic       out_multi;
  logic [2:0] count;
  logic       full;

  int errors = 0;
  int checks = 0;

  // Expected compare result packed as {hit, idx[1:0], multi}; expected alloc_err per pulse.
  logic [3:0] expQ[$];
  logic       errQ[$];

  localparam entry_t NONE = '0;

  np_comp_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_blk   (alloc_blk),
    .alloc_local (alloc_local),
    .alloc_done  (alloc_done),
    .alloc_err   (alloc_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_blk      (in_blk),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_hit     (out_hit),
    .out_idx     (out_idx),
    .out_multi   (out_multi),
    .count       (count),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic entry_t mk(input logic [9:0] a, input logic [1:0] b, input logic l);
    entry_t e;
    e.valid    = 1'b1;
    e.is_local = l;
    e.blk      = b;
    e.addr     = a;
    return e;
  endfunction

  // Drives one cycle of stimulus; entered and left #1 after a rising edge.
  task automatic applyStimulus(input entry_t a, input logic cv,
                               input logic [9:0] ca, input logic [1:0] cb);
    alloc_valid = a.valid;
    alloc_addr  = a.addr;
    alloc_blk   = a.blk;
    alloc_local = a.is_local;
    in_valid    = cv;
    in_addr     = ca;
    in_blk      = cb;
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    in_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(NONE, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) checkOutput("spurious_out_valid", int'(out_valid), 0);
      else checkOutput("compare_result", int'({out_hit, out_idx, out_multi}), int'(expQ.pop_front()));
    end
    if (alloc_done) begin
      if (errQ.size() == 0) checkOutput("spurious_alloc_done", int'(alloc_done), 0);
      else checkOutput("alloc_err", int'(alloc_err), int'(errQ.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b1;
    alloc_valid = 1'b0; alloc_addr = '0; alloc_blk = '0; alloc_local = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_blk = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_fields", int'({out_hit, out_idx, out_multi}), 0);
    checkOutput("rst_alloc_pulse", int'({alloc_done, alloc_err}), 0);
    rst_n = 1'b1;

    // Local spare: blocked-qualified hit and miss, first op right after reset release.
    errQ.push_back(1'b0); applyStimulus(mk(10'h155, 2'd2, 1'b1), 1'b0, '0, '0);
    expQ.push_back(4'b1_00_0); applyStimulus(NONE, 1'b1, 10'h155, 2'd2);
    expQ.push_back(4'b0_00_0); applyStimulus(NONE, 1'b1, 10'h155, 2'd1);
    checkOutput("count_one", int'(count), 1);
    idle(2);
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    checkOutput("clr_count", int'(count), 0);

    // Global plus local on the same row: multi-hit, lowest index wins.
    errQ.push_back(1'b0); applyStimulus(mk(10'h0A0, 2'd0, 1'b0), 1'b0, '0, '0);
    errQ.push_back(1'b0); applyStimulus(mk(10'h0A0, 2'd3, 1'b1), 1'b0, '0, '0);
    expQ.push_back(4'b1_00_1); applyStimulus(NONE, 1'b1, 10'h0A0, 2'd3);
    expQ.push_back(4'b1_00_0); applyStimulus(NONE, 1'b1, 10'h0A0, 2'd1);

    // Same-cycle alloc is not yet visible to the compare.
    errQ.push_back(1'b0); expQ.push_back(4'b0_00_0);
    applyStimulus(mk(10'h3FF, 2'd0, 1'b0), 1'b1, 10'h3FF, 2'd0);
    expQ.push_back(4'b1_10_0); applyStimulus(NONE, 1'b1, 10'h3FF, 2'd0);
    checkOutput("count_three", int'(count), 3);
    idle(1);

    // Backpressure: result holds, in_ready low, then no bubble on release.
    out_ready = 1'b0;
    expQ.push_back(4'b1_00_1); applyStimulus(NONE, 1'b1, 10'h0A0, 2'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_outputs", int'({out_valid, out_hit, out_idx, out_multi}), 5'b1_1_00_1);
      checkOutput("stall_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    expQ.push_back(4'b1_10_0); applyStimulus(NONE, 1'b1, 10'h3FF, 2'd0);
    checkOutput("no_bubble", int'({out_valid, out_hit, out_idx}), 4'b1_1_10);
    idle(1);
    checkOutput("out_valid_drops", int'(out_valid), 0);

    // clr with a held result and simultaneous alloc/compare: all discarded.
    out_ready = 1'b0;
    applyStimulus(NONE, 1'b1, 10'h0A0, 2'd0);
    checkOutput("pre_clr_state", int'({out_valid, count}), 4'b1_011);
    clr = 1'b1;
    alloc_valid = 1'b1; alloc_addr = 10'h123; alloc_blk = '0; alloc_local = 1'b0;
    in_valid = 1'b1; in_addr = 10'h0A0; in_blk = '0;
    #1;
    checkOutput("clr_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    clr = 1'b0; alloc_valid = 1'b0; in_valid = 1'b0;
    checkOutput("post_clr", int'({out_valid, full, count}), 0);
    out_ready = 1'b1;
    idle(1);

    // Fill to capacity, then one rejected alloc.
    for (int i = 1; i <= 4; i++) begin
      errQ.push_back(1'b0);
      applyStimulus(mk(10'(i), 2'd0, 1'b0), 1'b0, '0, '0);
    end
    checkOutput("full_state", int'({full, count}), 4'b1_100);
    errQ.push_back(1'b1); applyStimulus(mk(10'h2AA, 2'd0, 1'b0), 1'b0, '0, '0);
    checkOutput("sat_count", int'({full, count}), 4'b1_100);
    expQ.push_back(4'b1_11_0); applyStimulus(NONE, 1'b1, 10'h004, 2'd0);
    expQ.push_back(4'b0_00_0); applyStimulus(NONE, 1'b1, 10'h2AA, 2'd0);
    idle(2);

    // Async reset while a result and an alloc pulse are pending.
    applyStimulus(mk(10'h111, 2'd0, 1'b0), 1'b1, 10'h004, 2'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_outputs",
                int'({out_valid, out_hit, out_idx, out_multi, alloc_done, alloc_err, full, count}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    errQ.push_back(1'b0); applyStimulus(mk(10'h155, 2'd2, 1'b1), 1'b0, '0, '0);
    expQ.push_back(4'b1_00_0); applyStimulus(NONE, 1'b1, 10'h155, 2'd2);
    idle(3);

    for (int i = 0; i < 20 && (expQ.size() + errQ.size()) != 0; i++) idle(1);
    checkOutput("scoreboard_drained", expQ.size() + errQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/np_comp_bank.md
NP_COMP_BANK -- requirements
Module: np_comp_bank

Interface
REQ-001 Parameter ADDR_W, default 10, row-address width.
REQ-002 Parameter BLK_W, default 2, block-ID width.
REQ-003 Parameter N_ENT, default 4, range 2..16, number of redundant-row entries.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 clr  in  1  synchronous clear of all entries and the output stage.
REQ-007 alloc_valid  in  1  request to store a repair row.
REQ-008 alloc_addr  in  ADDR_W  row address to store.
REQ-009 alloc_blk  in  BLK_W  block ID to store.
REQ-010 alloc_local  in  1  1 = local spare (block-qualified), 0 = global spare.
REQ-011 alloc_done  out  1  one-cycle pulse, one cycle after any alloc_valid cycle.
REQ-012 alloc_err  out  1  valid with alloc_done; 1 = rejected because the bank was full.
REQ-013 in_valid  in  1  fault/pivot row compare request.
REQ-014 in_ready  out  1  bank accepts a compare request this cycle.
REQ-015 in_addr  in  ADDR_W  row address to compare.
REQ-016 in_blk  in  BLK_W  block ID to compare.
REQ-017 out_valid  out  1  compare result held.
REQ-018 out_ready  in  1  downstream consumes the result.
REQ-019 out_hit  out  1  at least one entry matched.
REQ-020 out_idx  out  clog2(N_ENT)  lowest matching entry index; 0 when no hit.
REQ-021 out_multi  out  1  two or more entries matched.
REQ-022 count  out  clog2(N_ENT+1)  number of valid entries.
REQ-023 full  out  1  count == N_ENT.

Function
REQ-024 Entry i SHALL match when: valid_i, addr_i == in_addr, and (local_i == 0 or blk_i == in_blk).
REQ-025 A request SHALL be accepted on in_valid && in_ready, with in_ready = !out_valid || out_ready.
REQ-026 The result of an accepted request SHALL appear in out_valid/out_hit/out_idx/out_multi on the next cycle. Latency is 1 cycle; back-to-back throughput is 1 per cycle while out_ready = 1.
REQ-027 While out_valid && !out_ready, all out_* signals SHALL hold stable.
REQ-028 out_valid SHALL clear after a consume cycle that has no new acceptance.
REQ-029 An accepted alloc (alloc_valid && !full) SHALL write entry[count] and increment count by 1. The written entry SHALL be visible to compares accepted from the next cycle onward, not the same cycle.
REQ-030 alloc_valid while full SHALL leave all entries and count unchanged. alloc_done = 1 and alloc_err = 1 on the next cycle.
REQ-031 Duplicate allocations SHALL be stored without checking.
REQ-032 count SHALL saturate at N_ENT and never wrap.
REQ-033 clr SHALL invalidate all entries, set count = 0, and drop out_valid on the next edge.
REQ-034 clr SHALL take priority over a simultaneous alloc or accept, which is discarded with no alloc_done.
REQ-035 in_ready SHALL be 0 in the cycle clr is high.

Reset
REQ-036 On rst_n low: all entries invalid, count = 0, full = 0, out_valid = 0, out_hit = 0, out_idx = 0, out_multi = 0, alloc_done = 0, alloc_err = 0.
REQ-037 Reset mid-transaction SHALL discard any pending result or allocation, with no pulse after release.
REQ-038 The first compare or allocation SHALL be accepted in the first cycle after rst_n deasserts.

Structure
REQ-039 A shared package SHALL hold the default widths (ADDR_W, BLK_W, N_ENT) and the entry record type {valid, local, blk, addr}.
REQ-040 One sub-module ra_cmp_cell SHALL implement the single-entry match of REQ-024. It is instantiated N_ENT times via generate; a priority encoder and popcount>=2 are in the top level.

Verification
REQ-041 Alloc (0x155, blk 2, local); compare (0x155, blk 2) -> 1 cycle later out_hit = 1, out_idx = 0, out_multi = 0; compare (0x155, blk 1) -> out_hit = 0.
REQ-042 Alloc global 0x0A0 then local 0x0A0 blk 3; compare (0x0A0, blk 3) -> out_hit = 1, out_idx = 0, out_multi = 1.
REQ-043 Five allocs with N_ENT = 4 -> count = 4, full = 1. Fifth alloc gives alloc_done = 1, alloc_err = 1; entries unchanged.
REQ-044 Hold out_ready = 0 for 3 cycles after a hit -> outputs stable, in_ready = 0. Then out_ready = 1 with a new in_valid -> next result in the following cycle with no bubble.
REQ-045 Alloc 0x3FF and compare 0x3FF in the same cycle -> out_hit = 0. Repeat the compare next cycle -> out_hit = 1.
REQ-046 clr while out_valid = 1 and count = 3 -> next cycle count = 0, out_valid = 0. Async rst_n low mid-stream -> all outputs 0 immediately.
